// File: rtl/lazer_pkg.sv
// rtl/lazer_pkg.sv - shared widths, park constants and FSM state type for the laser hit detector
package lazer_pkg;

   localparam int COORD_W = 11;
   localparam int SCORE_W = 14;

   localparam logic [COORD_W-1:0] PARK_THRESH = 11'd1024;
   localparam logic [COORD_W-1:0] PARK_POS    = 11'd1050;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HIT  = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lazer_box_overlap.sv
// rtl/lazer_box_overlap.sv - combinational axis-aligned bounding-box overlap test
module lazer_box_overlap
   import lazer_pkg::*;
#(
   parameter int A_W = 4,
   parameter int A_H = 16,
   parameter int B_W = 32,
   parameter int B_H = 24
) (
   input  logic [COORD_W-1:0] a_x,
   input  logic [COORD_W-1:0] a_y,
   input  logic [COORD_W-1:0] b_x,
   input  logic [COORD_W-1:0] b_y,
   output logic               overlap
);

   localparam logic [COORD_W:0] AW = (COORD_W+1)'(A_W);
   localparam logic [COORD_W:0] AH = (COORD_W+1)'(A_H);
   localparam logic [COORD_W:0] BW = (COORD_W+1)'(B_W);
   localparam logic [COORD_W:0] BH = (COORD_W+1)'(B_H);

   logic [COORD_W:0] ax, ay, bx, by;

   // One extra bit keeps position + size from wrapping near the screen edge
   always_comb begin
      ax = {1'b0, a_x};
      ay = {1'b0, a_y};
      bx = {1'b0, b_x};
      by = {1'b0, b_y};
      overlap = (ax < bx + BW) && (bx < ax + AW) &&
                (ay < by + BH) && (by < ay + AH);
   end

endmodule

// File: rtl/lazer_hit_detector.sv
// rtl/lazer_hit_detector.sv - per-frame laser vs enemy-table scan; LAZER_SCORE_EN enables the score adder
module lazer_hit_detector
   import lazer_pkg::*;
#(
   parameter int N_ENEMY   = 8,
   parameter int ENEMY_W   = 32,
   parameter int ENEMY_H   = 24,
   parameter int LAZER_W   = 4,
   parameter int LAZER_H   = 16,
   parameter int PTS       = 10,
   parameter int SCORE_MAX = 9999
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        move,
   input  logic [COORD_W-1:0]          lazer_x,
   input  logic [COORD_W-1:0]          lazer_y,
   output logic [idx_w(N_ENEMY)-1:0]   enemy_idx,
   input  logic [COORD_W-1:0]          enemy_x,
   input  logic [COORD_W-1:0]          enemy_y,
   input  logic                        enemy_alive,
   output logic                        collision,
   output logic                        kill_valid,
   output logic [idx_w(N_ENEMY)-1:0]   kill_idx,
   output logic [SCORE_W-1:0]          score
);

   localparam int              IDXW     = idx_w(N_ENEMY);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_ENEMY - 1);

   state_t              state_q, state_d;
   logic [COORD_W-1:0]  lx_q, lx_d, ly_q, ly_d;
   logic [IDXW-1:0]     enemy_idx_q, enemy_idx_d;
   logic [IDXW-1:0]     test_idx_q, test_idx_d;
   logic [IDXW-1:0]     hit_idx_q, hit_idx_d;
   logic                data_vld_q, data_vld_d;
   logic                collision_q, collision_d;
   logic                overlap, scan_hit, scan_last;

   lazer_box_overlap #(
      .A_W (LAZER_W),
      .A_H (LAZER_H),
      .B_W (ENEMY_W),
      .B_H (ENEMY_H)
   ) u_overlap (
      .a_x     (lx_q),
      .a_y     (ly_q),
      .b_x     (enemy_x),
      .b_y     (enemy_y),
      .overlap (overlap)
   );

   // Table data lags the address by one cycle, so the first SCAN cycle has nothing to test
   assign scan_hit  = data_vld_q && enemy_alive && overlap;
   assign scan_last = data_vld_q && (test_idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lx_q        <= '0;
         ly_q        <= '0;
         enemy_idx_q <= '0;
         test_idx_q  <= '0;
         hit_idx_q   <= '0;
         data_vld_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lx_q        <= lx_d;
         ly_q        <= ly_d;
         enemy_idx_q <= enemy_idx_d;
         test_idx_q  <= test_idx_d;
         hit_idx_q   <= hit_idx_d;
         data_vld_q  <= data_vld_d;
         collision_q <= collision_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (move && !collision_q && (lazer_x < PARK_THRESH)) state_d = SCAN;
         SCAN: begin
            if (scan_hit)       state_d = HIT;
            else if (scan_last) state_d = IDLE;
         end
         HIT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lx_d        = lx_q;
      ly_d        = ly_q;
      enemy_idx_d = enemy_idx_q;
      test_idx_d  = test_idx_q;
      hit_idx_d   = hit_idx_q;
      data_vld_d  = 1'b0;
      collision_d = collision_q;
      case (state_q)
         IDLE: begin
            enemy_idx_d = '0;
            if (move) begin
               if (collision_q) begin
                  collision_d = 1'b0;
               end else if (lazer_x < PARK_THRESH) begin
                  lx_d = lazer_x;
                  ly_d = lazer_y;
               end
            end
         end
         SCAN: begin
            data_vld_d = 1'b1;
            test_idx_d = enemy_idx_q;
            if (scan_hit || scan_last) enemy_idx_d = '0;
            else if (enemy_idx_q != LAST_IDX) enemy_idx_d = enemy_idx_q + 1'b1;
            if (scan_hit) hit_idx_d = test_idx_q;
         end
         HIT: collision_d = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      enemy_idx  = enemy_idx_q;
      kill_idx   = hit_idx_q;
      collision  = collision_q;
      kill_valid = (state_q == HIT);
   end

`ifdef LAZER_SCORE_EN
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W:0]   score_sum;

   always_comb begin
      score_sum = {1'b0, score_q} + (SCORE_W+1)'(PTS);
      score_d   = score_q;
      if (state_q == HIT) begin
         score_d = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                         : score_sum[SCORE_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) score_q <= '0;
      else        score_q <= score_d;
   end

   assign score = score_q;
`else
   logic unused_score_cfg;
   assign unused_score_cfg = ^{PTS, SCORE_MAX};
   assign score = '0;
`endif

endmodule

// File: tb/tb_lazer_hit_detector.sv
// tb/tb_lazer_hit_detector.sv - randomized self-checking bench with a frame-level reference model
module tb_lazer_hit_detector;

   localparam int N   = 8;
   localparam int EW  = 32;
   localparam int EH  = 24;
   localparam int LW  = 4;
   localparam int LH  = 16;
`ifdef LAZER_SCORE_EN
   localparam bit SCORE_ON = 1'b1;
`else
   localparam bit SCORE_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        move = 1'b0;
   logic [10:0] lazer_x = '0, lazer_y = '0;
   logic [10:0] enemy_x, enemy_y;
   logic        enemy_alive;
   logic [2:0]  enemy_idx, kill_idx;
   logic        collision, kill_valid;
   logic [13:0] score;

   int ex_tab [N];
   int ey_tab [N];
   bit al_tab [N];

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_coll = 1'b0;
   int exp_score = 0;

   lazer_hit_detector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .move        (move),
      .lazer_x     (lazer_x),
      .lazer_y     (lazer_y),
      .enemy_idx   (enemy_idx),
      .enemy_x     (enemy_x),
      .enemy_y     (enemy_y),
      .enemy_alive (enemy_alive),
      .collision   (collision),
      .kill_valid  (kill_valid),
      .kill_idx    (kill_idx),
      .score       (score)
   );

   always #5 clk = ~clk;

   // Enemy table with one-cycle registered read
   always @(posedge clk) begin
      enemy_x     <= 11'(ex_tab[enemy_idx]);
      enemy_y     <= 11'(ey_tab[enemy_idx]);
      enemy_alive <= al_tab[enemy_idx];
   end

   function automatic bit boxes_touch(input int lx, input int ly, input int ex, input int ey);
      return (lx < ex + EW) && (ex < lx + LW) && (ly < ey + EH) && (ey < ly + LH);
   endfunction

   // Frame-level reference: what one move tick should produce
   task automatic model_frame(input int lx, input int ly, output int eidx);
      eidx = -1;
      if (exp_coll) begin
         exp_coll = 1'b0;
         return;
      end
      if (lx >= 1024) return;
      for (int i = 0; i < N; i++)
         if (eidx < 0 && al_tab[i] && boxes_touch(lx, ly, ex_tab[i], ey_tab[i])) eidx = i;
      if (eidx >= 0) begin
         exp_coll = 1'b1;
         if (SCORE_ON) exp_score = (exp_score + 10 > 9999) ? 9999 : exp_score + 10;
      end
   endtask

   task automatic clear_tab();
      for (int i = 0; i < N; i++) begin
         ex_tab[i] = 900;
         ey_tab[i] = 700;
         al_tab[i] = 1'b0;
      end
   endtask

   task automatic do_frame(input int lx, input int ly, output int nk, output int kcyc,
                           output int kidx, output int maxidx, output bit coll_c0, output bit coll_c1);
      nk = 0; kcyc = -1; kidx = -1; maxidx = 0; coll_c1 = 1'b0;
      @(posedge clk); #1;
      move = 1'b1; lazer_x = 11'(lx); lazer_y = 11'(ly);
      @(negedge clk);
      coll_c0 = collision;
      @(posedge clk); #1;
      move = 1'b0;
      for (int c = 1; c <= N + 5; c++) begin
         @(negedge clk);
         if (c == 1) coll_c1 = collision;
         if (int'(enemy_idx) > maxidx) maxidx = int'(enemy_idx);
         if (kill_valid) begin
            nk++;
            if (kcyc < 0) begin
               kcyc = c;
               kidx = int'(kill_idx);
            end
         end
      end
   endtask

   task automatic settle();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      if (exp_coll) begin
         model_frame(0, 0, e);
         do_frame(0, 0, nk, kc, ki, mi, c0, c1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({collision, kill_valid, enemy_idx, kill_idx, score} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want all zero", {collision, kill_valid, enemy_idx, kill_idx, score});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({collision, kill_valid, enemy_idx, score} !== '0) begin
         n_bad++;
         $display("FAIL post_reset_idle: got %b want all zero", {collision, kill_valid, enemy_idx, score});
      end
   endtask

   task automatic test_first_hit();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      settle();
      clear_tab();
      al_tab[0] = 1'b1; ex_tab[0] = 90; ey_tab[0] = 290;
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (nk !== 1)  begin n_bad++; $display("FAIL first_hit_count: got %0d want 1", nk); end
      n_cmp++; if (kc !== 3)  begin n_bad++; $display("FAIL first_hit_cycle: got %0d want 3", kc); end
      n_cmp++; if (ki !== 0)  begin n_bad++; $display("FAIL first_hit_idx: got %0d want 0", ki); end
      n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL first_hit_coll: got %b want 1", collision); end
      n_cmp++; if (int'(score) !== exp_score) begin n_bad++; $display("FAIL first_hit_score: got %0d want %0d", score, exp_score); end
      // Next tick only clears the pending collision
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (c0 !== 1'b1) begin n_bad++; $display("FAIL coll_on_move: got %b want 1", c0); end
      n_cmp++; if (c1 !== 1'b0) begin n_bad++; $display("FAIL coll_after_move: got %b want 0", c1); end
      n_cmp++; if (nk !== 0)    begin n_bad++; $display("FAIL clear_frame_kills: got %0d want 0", nk); end
      n_cmp++; if (mi !== 0)    begin n_bad++; $display("FAIL clear_frame_idx: got %0d want 0", mi); end
   endtask

   task automatic test_index5();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      settle();
      clear_tab();
      for (int i = 0; i < N; i++) begin
         ex_tab[i] = (i % 2) ? 100 : 400;
         ey_tab[i] = (i % 2) ? 300 : 50;
         al_tab[i] = (i % 2) == 0;
      end
      al_tab[5] = 1'b1;
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (nk !== 1) begin n_bad++; $display("FAIL idx5_count: got %0d want 1", nk); end
      n_cmp++; if (ki !== 5) begin n_bad++; $display("FAIL idx5_idx: got %0d want 5", ki); end
      n_cmp++; if (kc !== 8) begin n_bad++; $display("FAIL idx5_cycle: got %0d want 8", kc); end
   endtask

   task automatic test_lowest_wins();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      settle();
      clear_tab();
      al_tab[2] = 1'b1; ex_tab[2] = 80;  ey_tab[2] = 295;
      al_tab[6] = 1'b1; ex_tab[6] = 101; ey_tab[6] = 310;
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (nk !== 1) begin n_bad++; $display("FAIL lowest_count: got %0d want 1", nk); end
      n_cmp++; if (ki !== 2) begin n_bad++; $display("FAIL lowest_idx: got %0d want 2", ki); end
   endtask

   task automatic test_parked();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      settle();
      clear_tab();
      al_tab[0] = 1'b1; ex_tab[0] = 1040; ey_tab[0] = 120;
      model_frame(1050, 128, e);
      do_frame(1050, 128, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL parked_kills: got %0d want 0", nk); end
      n_cmp++; if (mi !== 0) begin n_bad++; $display("FAIL parked_idx: got %0d want 0", mi); end
      n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL parked_coll: got %b want 0", collision); end
   endtask

   task automatic test_edges();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      settle();
      clear_tab();
      al_tab[0] = 1'b1; ex_tab[0] = 100; ey_tab[0] = 300;
      model_frame(132, 300, e);
      do_frame(132, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL edge_touch: got %0d kills want 0", nk); end
      model_frame(131, 300, e);
      do_frame(131, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (nk !== 1 || ki !== 0) begin n_bad++; $display("FAIL edge_inside: got %0d kills idx %0d want 1 idx 0", nk, ki); end
   endtask

   task automatic test_random();
      int e, nk, kc, ki, mi, lx, ly;
      bit c0, c1;
      for (int f = 0; f < 40; f++) begin
         lx = ($urandom_range(0, 7) == 0) ? 1050 : int'($urandom_range(0, 1023));
         ly = $urandom_range(0, 700);
         for (int i = 0; i < N; i++) begin
            al_tab[i] = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 3) == 0) begin
               ex_tab[i] = lx - 35 + int'($urandom_range(0, 42));
               ey_tab[i] = ly - 27 + int'($urandom_range(0, 45));
               if (ex_tab[i] < 0) ex_tab[i] = 0;
               if (ey_tab[i] < 0) ey_tab[i] = 0;
            end else begin
               ex_tab[i] = $urandom_range(0, 1000);
               ey_tab[i] = $urandom_range(0, 700);
            end
         end
         model_frame(lx, ly, e);
         do_frame(lx, ly, nk, kc, ki, mi, c0, c1);
         n_cmp++; if (nk !== ((e >= 0) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", f, nk, (e >= 0) ? 1 : 0); end
         if (e >= 0) begin
            n_cmp++; if (ki !== e)     begin n_bad++; $display("FAIL rnd%0d_idx: got %0d want %0d", f, ki, e); end
            n_cmp++; if (kc !== e + 3) begin n_bad++; $display("FAIL rnd%0d_cycle: got %0d want %0d", f, kc, e + 3); end
         end
         n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL rnd%0d_coll: got %b want %b", f, collision, exp_coll); end
         n_cmp++; if (c1 !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_coll_c1: got %b want 0", f, c1); end
         n_cmp++; if (int'(score) !== exp_score) begin n_bad++; $display("FAIL rnd%0d_score: got %0d want %0d", f, score, exp_score); end
      end
   endtask

   task automatic test_saturation();
      int e, nk, kc, ki, mi, iter;
      bit c0, c1;
      settle();
      clear_tab();
      al_tab[0] = 1'b1; ex_tab[0] = 90; ey_tab[0] = 290;
      iter = 0;
      while (SCORE_ON ? (exp_score < 9990) : (iter < 3)) begin
         model_frame(100, 300, e);
         do_frame(100, 300, nk, kc, ki, mi, c0, c1);
         settle();
         iter++;
      end
      n_cmp++; if (int'(score) !== exp_score) begin n_bad++; $display("FAIL sat_preload: got %0d want %0d", score, exp_score); end
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (int'(score) !== (SCORE_ON ? 9999 : 0)) begin n_bad++; $display("FAIL sat_clamp: got %0d want %0d", score, SCORE_ON ? 9999 : 0); end
      settle();
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (int'(score) !== (SCORE_ON ? 9999 : 0)) begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", score, SCORE_ON ? 9999 : 0); end
   endtask

   task automatic test_reset_mid_scan();
      int e, nk, kc, ki, mi;
      bit c0, c1;
      settle();
      clear_tab();
      al_tab[7] = 1'b1; ex_tab[7] = 90; ey_tab[7] = 290;
      @(posedge clk); #1;
      move = 1'b1; lazer_x = 11'd100; lazer_y = 11'd300;
      @(posedge clk); #1;
      move = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (score !== '0)      begin n_bad++; $display("FAIL rst_scan_score: got %0d want 0", score); end
      n_cmp++; if (enemy_idx !== '0)  begin n_bad++; $display("FAIL rst_scan_idx: got %0d want 0", enemy_idx); end
      n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL rst_scan_coll: got %b want 0", collision); end
      @(negedge clk) rst_n = 1'b1;
      exp_coll = 1'b0;
      exp_score = 0;
      nk = 0;
      repeat (N + 4) begin
         @(negedge clk);
         if (kill_valid) nk++;
      end
      n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL rst_scan_aborted: got %0d kills want 0", nk); end
      // Reset while a hit is pending must drop collision at once
      model_frame(100, 300, e);
      do_frame(100, 300, nk, kc, ki, mi, c0, c1);
      n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL rst_pre_coll: got %b want 1", collision); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL rst_coll_async: got %b want 0", collision); end
      @(negedge clk) rst_n = 1'b1;
      exp_coll = 1'b0;
      exp_score = 0;
   endtask

   initial begin
      clear_tab();
      test_reset();
      test_first_hit();
      test_index5();
      test_lowest_wins();
      test_parked();
      test_edges();
      test_random();
      test_saturation();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
